// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline (between EX/M and m_wb).
// Non-memory ops pass straight through. Loads and stores go out on a
// req/ready + rvalid data bus. The stage stalls upstream and skips m_wb
// until the access finishes.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W
// accesses through an extra misalign_trap output. Without it, the low
// address bits below the access size are ignored.
module mem_stage #(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [4:0]  rd_addr_in,
  input  logic        writeback_en_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_out,
  output logic        writeback_en_out,
  output logic        writeback_from_mem_out,
  output logic        skip_out,
  output logic        stall_out,
  output logic        bus_error
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [16:0] cnt_inc;
  logic        bus_error_reg, bus_error_next;
  // Response that arrived in the same cycle the bus accepted the load.
  logic        pend_reg, pend_next;
  logic [31:0] pend_data_reg, pend_data_next;

  logic        is_mem;
  logic        is_load;
  logic        misaligned;
  logic        trap;
  logic [1:0]  acc_size;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  assign is_mem   = valid_in & (mem_read | mem_write);
  assign is_load  = mem_read;  // read+write together behaves as a load
  assign acc_size = funct3[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = (acc_size == 2'b01 && alu_result[0]) ||
                      (acc_size[1] && alu_result[1:0] != 2'b00);
  assign misalign_trap = trap;
`else
  assign misaligned = 1'b0;
`endif

  assign dmem_we     = mem_write & ~mem_read;
  assign dmem_addr   = {alu_result[31:2], 2'b00};
  assign rd_addr_out = rd_addr_in;
  assign stall_out   = skip_out;
  assign bus_error   = bus_error_reg;

  // Per-lane strobe and replicated write data; H ignores addr[0], W ignores addr[1:0].
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign dmem_wstrb[gi] = (acc_size == 2'b00) ? (alu_result[1:0] == LANE) :
                            (acc_size == 2'b01) ? (alu_result[1] == LANE[1]) : 1'b1;
    assign dmem_wdata[8*gi +: 8] = (acc_size == 2'b00) ? store_data[7:0] :
                                   (acc_size == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                                         store_data[8*gi +: 8];
  end

  assign resp_valid = dmem_rvalid | pend_reg;
  assign resp_data  = pend_reg ? pend_data_reg : dmem_rdata;

  // Lane selection and sign/zero extension of the returned load word.
  always_comb begin
    byte_lane = resp_data[7:0];
    case (alu_result[1:0])
      2'd1:    byte_lane = resp_data[15:8];
      2'd2:    byte_lane = resp_data[23:16];
      2'd3:    byte_lane = resp_data[31:24];
      default: byte_lane = resp_data[7:0];
    endcase
    half_lane = alu_result[1] ? resp_data[31:16] : resp_data[15:0];
    case (funct3)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'd0, byte_lane};
      3'b101:  load_ext = {16'd0, half_lane};
      default: load_ext = resp_data;
    endcase
  end

  assign cnt_inc = {1'b0, cnt_reg} + 17'd1;

  // Next-state and output decode for the IDLE/REQ/WAIT_RESP access FSM.
  always_comb begin
    state_next             = state_reg;
    cnt_next               = cnt_reg;
    bus_error_next         = 1'b0;
    pend_next              = pend_reg;
    pend_data_next         = pend_data_reg;
    dmem_req               = 1'b0;
    skip_out               = 1'b0;
    rd_out                 = alu_result;
    writeback_en_out       = 1'b0;
    writeback_from_mem_out = 1'b0;
    trap                   = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        pend_next = 1'b0;
        if (!is_mem) begin
          writeback_en_out = valid_in & writeback_en_in;
        end else if (misaligned) begin
          trap = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            if (is_load) begin
              skip_out       = 1'b1;
              state_next     = WAIT_RESP;
              pend_next      = dmem_rvalid;
              pend_data_next = dmem_rdata;
            end
          end else begin
            skip_out   = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        skip_out = 1'b1;
        if (dmem_ready) begin
          if (is_load) begin
            state_next     = WAIT_RESP;
            pend_next      = dmem_rvalid;
            pend_data_next = dmem_rdata;
          end else begin
            skip_out   = 1'b0;
            state_next = IDLE;
          end
        end
      end
      WAIT_RESP: begin
        skip_out = 1'b1;
        cnt_next = cnt_inc[15:0];
        if (resp_valid) begin
          skip_out               = 1'b0;
          rd_out                 = load_ext;
          writeback_en_out       = valid_in & writeback_en_in;
          writeback_from_mem_out = 1'b1;
          state_next             = IDLE;
          cnt_next               = '0;
          pend_next              = 1'b0;
        end else if (cnt_inc == 17'(RESP_TIMEOUT)) begin
          // Give up: release the pipeline with a zero result, flag error next cycle.
          skip_out       = 1'b0;
          rd_out         = '0;
          state_next     = IDLE;
          cnt_next       = '0;
          bus_error_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Outputs are combinational, so mask them while reset is held.
    if (!rst) begin
      dmem_req               = 1'b0;
      skip_out               = 1'b0;
      writeback_en_out       = 1'b0;
      writeback_from_mem_out = 1'b0;
      trap                   = 1'b0;
    end
  end

  // State, timeout counter, error pulse and captured early response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bus_error_reg <= 1'b0;
      pend_reg      <= 1'b0;
      pend_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bus_error_reg <= bus_error_next;
      pend_reg      <= pend_next;
      pend_data_reg <= pend_data_next;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized transaction bench for mem_stage.
// The bench acts as the data memory. It uses a transaction-level model to
// predict the stall length, bus fields and writeback result of every access.
module tb_mem_stage;

  localparam int RESP_TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        mem_read;
  logic        mem_write;
  logic [4:0]  rd_addr_in;
  logic        writeback_en_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;
  logic        writeback_en_out;
  logic        writeback_from_mem_out;
  logic        skip_out;
  logic        stall_out;
  logic        bus_error;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int txn_no   = 0;
  bit err_pending = 1'b0;

  mem_stage #(.RESP_TIMEOUT(RESP_TO)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .valid_in               (valid_in),
    .alu_result             (alu_result),
    .store_data             (store_data),
    .funct3                 (funct3),
    .mem_read               (mem_read),
    .mem_write              (mem_write),
    .rd_addr_in             (rd_addr_in),
    .writeback_en_in        (writeback_en_in),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_wstrb             (dmem_wstrb),
    .dmem_ready             (dmem_ready),
    .dmem_rvalid            (dmem_rvalid),
    .dmem_rdata             (dmem_rdata),
    .rd_addr_out            (rd_addr_out),
    .rd_out                 (rd_out),
    .writeback_en_out       (writeback_en_out),
    .writeback_from_mem_out (writeback_from_mem_out),
    .skip_out               (skip_out),
    .stall_out              (stall_out),
    .bus_error              (bus_error)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_trap          (misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (txn %0d): got 0x%08h expected 0x%08h", tag, txn_no, got, exp);
    end
  endtask

  // Expected load result: pick the addressed byte/half arithmetically, then extend.
  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
    logic [31:0] v;
    int unsigned sh;
    case (f3)
      3'b000, 3'b100: begin
        sh = 8 * int'(addr[1:0]);
        v  = (word >> sh) & 32'h0000_00FF;
        if (f3 == 3'b000 && v >= 32'h80) v = v - 32'h100;
      end
      3'b001, 3'b101: begin
        sh = addr[1] ? 16 : 0;
        v  = (word >> sh) & 32'h0000_FFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] addr, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001 << addr[1:0];
      2'b01:   return addr[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] data, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return (data & 32'hFF) * 32'h0101_0101;
      2'b01:   return (data & 32'hFFFF) * 32'h0001_0001;
      default: return data;
    endcase
  endfunction

  // One instruction held in EX/M until it completes.
  // kind: 0 = ALU, 1 = load, 2 = store.
  // d_r: cycles before the bus accepts the request.
  // d_v: cycles from acceptance to rvalid (0 = same cycle, -1 = never).
  task automatic run_txn(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rword, input int d_r,
                         input int d_v, input logic wben, input logic both);
    int          done_c;
    bit          tmo;
    bit          req_exp;
    logic [31:0] exp_rd;
    logic        exp_wb;
    logic        exp_fm;
    logic [4:0]  rd;
    rd  = 5'($urandom);
    tmo = (kind == 1) && (d_v < 0);
    if (kind == 0)      done_c = 0;
    else if (kind == 2) done_c = d_r;
    else if (tmo)       done_c = d_r + RESP_TO;
    else if (d_v == 0)  done_c = d_r + 1;
    else                done_c = d_r + d_v;
    exp_rd = addr;
    exp_wb = wben;
    exp_fm = 1'b0;
    if (kind == 1) begin
      exp_rd = tmo ? 32'h0 : model_load(rword, addr, f3);
      exp_wb = tmo ? 1'b0 : wben;
      exp_fm = !tmo;
    end else if (kind == 2) begin
      exp_wb = 1'b0;
    end
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      valid_in        = 1'b1;
      alu_result      = addr;
      store_data      = sdata;
      funct3          = f3;
      mem_read        = (kind == 1);
      mem_write       = (kind == 2) || (kind == 1 && both);
      rd_addr_in      = rd;
      writeback_en_in = wben;
      dmem_ready      = (kind != 0) && (c == d_r);
      if (kind == 0) dmem_rvalid = 1'($urandom);
      else           dmem_rvalid = (kind == 1) && !tmo && (c == d_r + d_v);
      dmem_rdata      = (kind == 1 && dmem_rvalid) ? rword : $urandom;
      #1;
      req_exp = (kind != 0) && (c <= d_r);
      check_val("skip", skip_out, c != done_c);
      check_val("stall", stall_out, c != done_c);
      check_val("bus_error", bus_error, err_pending);
      err_pending = 1'b0;
      check_val("req", dmem_req, req_exp);
      if (req_exp) begin
        check_val("addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check_val("we", dmem_we, kind == 2);
        if (kind == 2) begin
          check_val("wstrb", dmem_wstrb, model_strb(addr, f3));
          check_val("wdata", dmem_wdata, model_wdata(sdata, f3));
        end
      end
      if (c == done_c) begin
        if (kind != 2) check_val("rd_out", rd_out, exp_rd);
        check_val("wb_en", writeback_en_out, exp_wb);
        check_val("from_mem", writeback_from_mem_out, exp_fm);
        check_val("rd_addr", rd_addr_out, rd);
      end
    end
    err_pending = tmo;
    $display("txn %0d kind=%0d f3=%0d addr=%08h ready_dly=%0d rvalid_dly=%0d rd_out=%08h",
             txn_no, kind, f3, addr, d_r, d_v, rd_out);
    txn_no++;
  endtask

  // A bubble: nothing valid in EX/M, so the stage must stay quiet.
  task automatic idle_cycle();
    @(negedge clk);
    valid_in        = 1'b0;
    mem_read        = 1'($urandom);
    mem_write       = 1'($urandom);
    alu_result      = $urandom;
    writeback_en_in = 1'b1;
    dmem_ready      = 1'($urandom);
    dmem_rvalid     = 1'($urandom);
    dmem_rdata      = $urandom;
    #1;
    check_val("idle_req", dmem_req, 1'b0);
    check_val("idle_skip", skip_out, 1'b0);
    check_val("idle_wb_en", writeback_en_out, 1'b0);
    check_val("idle_from_mem", writeback_from_mem_out, 1'b0);
    check_val("idle_bus_error", bus_error, err_pending);
    err_pending = 1'b0;
  endtask

  initial begin
    logic [2:0]  load_f3 [5];
    logic [2:0]  f3;
    logic [31:0] addr;
    int          kind;
    load_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset with a load presented: nothing may leave the stage.
    rst             = 1'b0;
    valid_in        = 1'b1;
    mem_read        = 1'b1;
    mem_write       = 1'b0;
    alu_result      = 32'h40;
    store_data      = '0;
    funct3          = 3'b010;
    rd_addr_in      = 5'd1;
    writeback_en_in = 1'b1;
    dmem_ready      = 1'b0;
    dmem_rvalid     = 1'b0;
    dmem_rdata      = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_val("rst_req", dmem_req, 1'b0);
      check_val("rst_skip", skip_out, 1'b0);
      check_val("rst_stall", stall_out, 1'b0);
      check_val("rst_bus_error", bus_error, 1'b0);
    end
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b0;
    idle_cycle();

    // Directed cases.
    run_txn(0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);          // ADD pass-through
    run_txn(1, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0, 3, 1'b1, 1'b0);  // LB, sign-extended top byte
    run_txn(2, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 3, 0, 1'b0, 1'b0);  // SH, slow ready
    run_txn(1, 3'b101, 32'h0000_0206, 32'h0, 32'hBEEF_1234, 1, 0, 1'b1, 1'b1);  // LHU, rvalid with ready, rd+wr
    run_txn(1, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, -1, 1'b1, 1'b0);         // LW, no response
    idle_cycle();                                                                // bus_error pulse
    idle_cycle();                                                                // pulse gone

    // Reset while waiting for a load response; the late response must be dropped.
    @(negedge clk);
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_result = 32'h200; dmem_ready = 1'b1; dmem_rvalid = 1'b0;
    #1;
    check_val("mid_req", dmem_req, 1'b1);
    check_val("mid_skip", skip_out, 1'b1);
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    check_val("mid_wait_skip", skip_out, 1'b1);
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    #1;
    check_val("mid_rst_req", dmem_req, 1'b0);
    check_val("mid_rst_skip", skip_out, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
      #1;
      check_val("late_wb_en", writeback_en_out, 1'b0);
      check_val("late_from_mem", writeback_from_mem_out, 1'b0);
      check_val("late_skip", skip_out, 1'b0);
      check_val("late_req", dmem_req, 1'b0);
      check_val("late_bus_error", bus_error, 1'b0);
    end

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom;
      if (kind == 1)      f3 = load_f3[$urandom_range(0, 4)];
      else if (kind == 2) f3 = 3'($urandom_range(0, 2));
      else                f3 = 3'($urandom);
`ifdef MEM_MISALIGN_TRAP_EN
      addr[1:0] = 2'b00;
`endif
      run_txn(kind, f3, addr, $urandom, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
